// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
// data_memory_lsu : byte-addressable RV32I data memory, valid/ready LSU front
// Rev 1.0 : initial release
// ============================================================================
module data_memory_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_oob,
  output logic        rsp_illegal
);

  localparam int          C_AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] C_INIT_WORD = INIT_ZERO ? 32'h0 : 'x;

  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] rdata_q;
  logic        mis_q, oob_q, ill_q;
  // Contents come up zeroed only through initialisation; reset never touches them.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: C_INIT_WORD};

  logic            w_accept;
  logic [C_AW-1:0] w_widx;
  logic [1:0]      w_off;
  logic            w_ill, w_oob_raw, w_mis_raw, w_oob, w_mis, w_err;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [3:0]      w_be;
  logic [31:0]     w_wlane;
  logic [31:0]     rdata_d;

  assign req_ready = (state_q == S_EMPTY) || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  assign w_widx    = req_addr[C_AW+1:2];
  assign w_off     = req_addr[1:0];
  assign w_oob_raw = (req_addr >> (C_AW + 2)) != 32'd0;

  assign w_ill = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
  assign w_mis_raw = ((req_funct3[1:0] == 2'b01) && w_off[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (w_off != 2'b00));

  // Only the highest-priority error is reported: illegal > oob > misaligned.
  assign w_oob = !w_ill && w_oob_raw;
  assign w_mis = !w_ill && !w_oob_raw && w_mis_raw;
  assign w_err = w_ill || w_oob_raw || w_mis_raw;

  assign w_word = mem_q[w_widx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    rdata_d = 32'h0;
    if (!w_err && !req_write) begin
      case (req_funct3)
        3'b000:  rdata_d = {{24{w_byte[7]}}, w_byte};
        3'b001:  rdata_d = {{16{w_half[15]}}, w_half};
        3'b010:  rdata_d = w_word;
        3'b100:  rdata_d = {24'h0, w_byte};
        3'b101:  rdata_d = {16'h0, w_half};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  // A store presented while reset is high is dropped along with everything else.
  always_ff @(posedge clk) begin
    if (!reset && w_accept && req_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) mem_q[w_widx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
      oob_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (w_accept) begin
      state_q <= S_FULL;
      rdata_q <= rdata_d;
      mis_q   <= w_mis;
      oob_q   <= w_oob;
      ill_q   <= w_ill;
    end else if (rsp_ready) begin
      state_q <= S_EMPTY;
    end
  end

  assign rsp_valid      = (state_q == S_FULL);
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = mis_q;
  assign rsp_oob        = oob_q;
  assign rsp_illegal    = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_lsu.sv
`default_nettype none
// ============================================================================
// tb_data_memory_lsu : directed self-checking bench for data_memory_lsu
// Rev 1.0 : initial release
// ============================================================================
module tb_data_memory_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_oob;
  logic        rsp_illegal;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

  data_memory_lsu #(.DEPTH_WORDS(256), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_misaligned(rsp_misaligned), .rsp_oob(rsp_oob), .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  // Flags packed as {misaligned, oob, illegal}.
  task automatic expect_rsp(input string tag, input logic [31:0] rd, input logic [2:0] fl);
    chk({tag, ".valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, ".rdata"}, rsp_rdata, rd);
    chk({tag, ".flags"}, {29'h0, rsp_misaligned, rsp_oob, rsp_illegal}, {29'h0, fl});
  endtask

  // One request, one cycle, response checked at the following negedge.
  task automatic xfer(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input logic [2:0] fl);
    drive(w, f3, a, d);
    rsp_ready = 1'b1;
    #1;
    chk({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    expect_rsp(tag, rd, fl);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    step(); step();
    chk("rst.valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst.rdata", rsp_rdata, 32'h0);
    chk("rst.flags", {29'h0, rsp_misaligned, rsp_oob, rsp_illegal}, 32'h0);
    reset = 1'b0;

    // Width and extension of loads from one stored word
    xfer("sw10",  1'b1, F_W,  32'h10, 32'h8081_82F3, 32'h0, 3'b000);
    xfer("lb10",  1'b0, F_B,  32'h10, 32'h0, 32'hFFFF_FFF3, 3'b000);
    xfer("lbu10", 1'b0, F_BU, 32'h10, 32'h0, 32'h0000_00F3, 3'b000);
    xfer("lh10",  1'b0, F_H,  32'h10, 32'h0, 32'hFFFF_82F3, 3'b000);
    xfer("lhu10", 1'b0, F_HU, 32'h10, 32'h0, 32'h0000_82F3, 3'b000);
    xfer("lw10",  1'b0, F_W,  32'h10, 32'h0, 32'h8081_82F3, 3'b000);
    xfer("lb13",  1'b0, F_B,  32'h13, 32'h0, 32'hFFFF_FF80, 3'b000);
    xfer("lhu12", 1'b0, F_HU, 32'h12, 32'h0, 32'h0000_8081, 3'b000);

    // Partial stores touch only their lanes
    xfer("sw20",  1'b1, F_W, 32'h20, 32'h0, 32'h0, 3'b000);
    xfer("sb21",  1'b1, F_B, 32'h21, 32'hAAAA_AA55, 32'h0, 3'b000);
    xfer("lw20a", 1'b0, F_W, 32'h20, 32'h0, 32'h0000_5500, 3'b000);
    xfer("sh22",  1'b1, F_H, 32'h22, 32'h1234_BEEF, 32'h0, 3'b000);
    xfer("lw20b", 1'b0, F_W, 32'h20, 32'h0, 32'hBEEF_5500, 3'b000);

    // Error detection and priority
    xfer("lh11_mis",  1'b0, F_H,   32'h11,  32'h0, 32'h0, 3'b100);
    xfer("sw12_mis",  1'b1, F_W,   32'h12,  32'hDEAD_BEEF, 32'h0, 3'b100);
    xfer("lw10_keep", 1'b0, F_W,   32'h10,  32'h0, 32'h8081_82F3, 3'b000);
    xfer("lw400_oob", 1'b0, F_W,   32'h400, 32'h0, 32'h0, 3'b010);
    xfer("lw401_oob", 1'b0, F_W,   32'h401, 32'h0, 32'h0, 3'b010);
    xfer("f011_ill",  1'b0, F_BAD, 32'h10,  32'h0, 32'h0, 3'b001);
    xfer("ill_prio",  1'b0, F_BAD, 32'h401, 32'h0, 32'h0, 3'b001);
    xfer("sbu_ill",   1'b1, F_BU,  32'h10,  32'hFFFF_FFFF, 32'h0, 3'b001);
    xfer("lw10_keep2",1'b0, F_W,   32'h10,  32'h0, 32'h8081_82F3, 3'b000);

    // Back-to-back store then load of the same word
    xfer("b2b_sw", 1'b1, F_W, 32'h30, 32'h1234_5678, 32'h0, 3'b000);
    xfer("b2b_lw", 1'b0, F_W, 32'h30, 32'h0, 32'h1234_5678, 3'b000);

    // Backpressure: the response must hold while the next request waits
    drive(1'b0, F_W, 32'h30, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    drive(1'b0, F_W, 32'h20, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.req_ready", {31'h0, req_ready}, 32'h0);
      expect_rsp("bp.hold", 32'h1234_5678, 3'b000);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.release_ready", {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    expect_rsp("bp.next", 32'hBEEF_5500, 3'b000);

    // Reset with a response pending and a store presented during reset
    drive(1'b0, F_W, 32'h10, 32'h0);
    step();
    drive(1'b1, F_W, 32'h10, 32'hFFFF_FFFF);
    reset = 1'b1;
    step();
    chk("rstp.valid", {31'h0, rsp_valid}, 32'h0);
    chk("rstp.rdata", rsp_rdata, 32'h0);
    chk("rstp.flags", {29'h0, rsp_misaligned, rsp_oob, rsp_illegal}, 32'h0);
    reset = 1'b0;
    req_valid = 1'b0;
    step();
    chk("rstp.idle", {31'h0, rsp_valid}, 32'h0);
    xfer("rstp.lw10", 1'b0, F_W, 32'h10, 32'h0, 32'h8081_82F3, 3'b000);
    xfer("rstp.lw20", 1'b0, F_W, 32'h20, 32'h0, 32'hBEEF_5500, 3'b000);
    step();
    chk("end.idle", {31'h0, rsp_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
